// File: rtl/rv32_mem_arbiter_if.sv
// Bus bundle between the core's fetch (I) / load-store (D) ports, the arbiter and the shared memory.
// slave = arbiter view; master = core + memory view.
interface rv32_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int SEL_W = DATA_W / 8;

   logic              i_req_i;
   logic [ADDR_W-1:0] i_addr_i;
   logic              i_gnt_o;
   logic              i_rvalid_o;
   logic [DATA_W-1:0] i_rdata_o;

   logic              d_req_i;
   logic              d_we_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic [DATA_W-1:0] d_wdata_i;
   logic [SEL_W-1:0]  d_sel_i;
   logic              d_lock_i;
   logic              d_gnt_o;
   logic              d_rvalid_o;
   logic [DATA_W-1:0] d_rdata_o;

   logic              mem_ce_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [SEL_W-1:0]  mem_sel_o;
   logic [DATA_W-1:0] mem_rdata_i;

   modport slave (
      input  i_req_i, i_addr_i,
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i, d_lock_i,
      input  mem_rdata_i,
      output i_gnt_o, i_rvalid_o, i_rdata_o,
      output d_gnt_o, d_rvalid_o, d_rdata_o,
      output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o
   );

   modport master (
      output i_req_i, i_addr_i,
      output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i, d_lock_i,
      output mem_rdata_i,
      input  i_gnt_o, i_rvalid_o, i_rdata_o,
      input  d_gnt_o, d_rvalid_o, d_rdata_o,
      input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o
   );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Two-master (I fetch / D load-store) arbiter onto one single-port sync memory.
// Grant is combinational in the access cycle, response 1 cycle later; D has priority, I anti-starvation, D lock.
module rv32_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   rv32_mem_arbiter_if.slave bus
);
   localparam int         SEL_W = DATA_W / 8;
   localparam logic [3:0] SMAX  = 4'(STARVE_MAX);

   typedef enum logic {UNLOCKED, LOCKED} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   logic [3:0]  starve_q, starve_d;
   logic        gnt_i, gnt_d;

   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;
   logic [SEL_W-1:0]  sel_mux;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= UNLOCKED;
         owner_q  <= OWN_NONE;
         starve_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      gnt_i   = 1'b0;
      gnt_d   = 1'b0;
      state_d = state_q;
      // Grants are suppressed while reset is asserted so every output is quiet.
      if (rst_i) begin
         if (state_q == LOCKED) begin
            gnt_d = bus.d_req_i;
         end else if (bus.i_req_i && bus.d_req_i) begin
            gnt_i = (starve_q == SMAX);
            gnt_d = !gnt_i;
         end else begin
            gnt_i = bus.i_req_i;
            gnt_d = bus.d_req_i;
         end
      end
      if (gnt_d) begin
         state_d = bus.d_lock_i ? LOCKED : UNLOCKED;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!bus.i_req_i || gnt_i) begin
         starve_d = 4'd0;
      end else if (starve_q != SMAX) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      if (gnt_i) begin
         owner_d = OWN_I;
      end else if (gnt_d) begin
         owner_d = OWN_D;
      end
   end

   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      sel_mux   = '0;
      if (gnt_i) begin
         addr_mux = bus.i_addr_i;
         sel_mux  = '1;
      end else if (gnt_d) begin
         addr_mux  = bus.d_addr_i;
         wdata_mux = bus.d_wdata_i;
         sel_mux   = bus.d_sel_i;
      end
   end

   assign bus.i_gnt_o     = gnt_i;
   assign bus.d_gnt_o     = gnt_d;
   assign bus.mem_ce_o    = gnt_i | gnt_d;
   assign bus.mem_we_o    = gnt_d & bus.d_we_i;
   assign bus.mem_addr_o  = addr_mux;
   assign bus.mem_wdata_o = wdata_mux;
   assign bus.mem_sel_o   = sel_mux;

   // Qualified by rst_i so an access granted just before reset never answers.
   assign bus.i_rvalid_o = rst_i && (owner_q == OWN_I);
   assign bus.d_rvalid_o = rst_i && (owner_q == OWN_D);
   assign bus.i_rdata_o  = bus.i_rvalid_o ? bus.mem_rdata_i : '0;
   assign bus.d_rdata_o  = bus.d_rvalid_o ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: directed scenarios then random traffic, a per-cycle grant model
// and a response scoreboard fed from the model and drained by a monitor on rvalid.
module tb_rv32_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SM = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rv32_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   rv32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      bit          is_d;
      bit          is_wr;
      logic [31:0] data;
      int          due;
   } resp_t;
   resp_t sb[$];

   logic [31:0] dev  [256];
   logic [31:0] refm [256];

   // Reference model state: lock flag and number of consecutive contested losses of I.
   bit m_lock = 1'b0;
   int m_lost = 0;

   function automatic logic [31:0] preload(int i);
      return (i == 64) ? 32'h0000_0013 : ((32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory device: responds one cycle after the strobe, garbage when not accessed.
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) dev[i] <= preload(i);
         bus.mem_rdata_i <= '0;
      end else if (bus.mem_ce_o) begin
         if (bus.mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_sel_o[b]) dev[bus.mem_addr_o[9:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
            bus.mem_rdata_i <= '0;
         end else begin
            bus.mem_rdata_i <= dev[bus.mem_addr_o[9:2]];
         end
      end else begin
         bus.mem_rdata_i <= $urandom;
      end
   end

   // Grant model: decides who should win from the arbitration rules and pushes expected responses.
   always @(negedge clk) begin
      bit ir, dr, ei, ed;
      logic [31:0] ea, ew;
      logic [3:0]  es;
      resp_t r;
      ir = bus.i_req_i;
      dr = bus.d_req_i;
      ei = 1'b0;
      ed = 1'b0;
      if (!rst) begin
         m_lock = 1'b0;
         m_lost = 0;
         for (int i = 0; i < 256; i++) refm[i] = preload(i);
      end else begin
         if (m_lock) ed = dr;
         else if (ir && dr) begin
            ei = (m_lost == SM);
            ed = !ei;
         end else begin
            ei = ir;
            ed = dr;
         end
      end
      ea = ei ? bus.i_addr_i : (ed ? bus.d_addr_i : 32'h0);
      ew = ed ? bus.d_wdata_i : 32'h0;
      es = ei ? 4'hF : (ed ? bus.d_sel_i : 4'h0);
      chk("i_gnt", bus.i_gnt_o, ei);
      chk("d_gnt", bus.d_gnt_o, ed);
      chk("mem_ce", bus.mem_ce_o, ei | ed);
      chk("mem_we", bus.mem_we_o, ed & bus.d_we_i);
      chk("mem_addr", bus.mem_addr_o, ea);
      chk("mem_wdata", bus.mem_wdata_o, ew);
      chk("mem_sel", bus.mem_sel_o, es);
      if (rst) begin
         if (ed) begin
            r.is_d = 1'b1;
            r.is_wr = bus.d_we_i;
            r.data = refm[bus.d_addr_i[9:2]];
            r.due = cyc + 1;
            if (bus.d_we_i)
               for (int b = 0; b < 4; b++)
                  if (bus.d_sel_i[b]) refm[bus.d_addr_i[9:2]][8*b +: 8] = bus.d_wdata_i[8*b +: 8];
            sb.push_back(r);
            m_lock = bus.d_lock_i;
         end
         if (ei) begin
            r.is_d = 1'b0;
            r.is_wr = 1'b0;
            r.data = refm[bus.i_addr_i[9:2]];
            r.due = cyc + 1;
            sb.push_back(r);
         end
         if (!ir || ei) m_lost = 0;
         else if (m_lost < SM) m_lost = m_lost + 1;
      end
   end

   // Response monitor: drains the scoreboard whenever a response is due.
   always @(negedge clk) begin
      resp_t e;
      if (!rst) begin
         sb.delete();
         chk("rst_i_rvalid", bus.i_rvalid_o, 1'b0);
         chk("rst_d_rvalid", bus.d_rvalid_o, 1'b0);
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("i_rvalid", bus.i_rvalid_o, !e.is_d);
         chk("d_rvalid", bus.d_rvalid_o, e.is_d);
         if (!e.is_wr) begin
            if (e.is_d) chk("d_rdata", bus.d_rdata_o, e.data);
            else        chk("i_rdata", bus.i_rdata_o, e.data);
         end
      end else begin
         chk("idle_i_rvalid", bus.i_rvalid_o, 1'b0);
         chk("idle_d_rvalid", bus.d_rvalid_o, 1'b0);
      end
      if (!bus.i_rvalid_o) chk("i_rdata_zero", bus.i_rdata_o, 32'h0);
      if (!bus.d_rvalid_o) chk("d_rdata_zero", bus.d_rdata_o, 32'h0);
   end

   task automatic d_issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] s, input logic lk);
      logic g;
      g = 1'b0;
      bus.d_req_i   = 1'b1;
      bus.d_we_i    = we;
      bus.d_addr_i  = a;
      bus.d_wdata_i = wd;
      bus.d_sel_i   = s;
      bus.d_lock_i  = lk;
      for (int t = 0; t < 100 && !g; t++) begin
         @(negedge clk);
         g = bus.d_gnt_o;
         @(posedge clk); #1;
      end
      if (!g) begin
         n_cmp++;
         n_bad++;
         $display("FAIL d_issue_timeout: got no grant expected grant within 100 cycles");
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
   endfunction

   initial begin
      logic ig, dg;
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h0;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h0;
      bus.d_wdata_i = 32'h0; bus.d_sel_i = 4'hF; bus.d_lock_i = 1'b0;

      // Reset held with both requests active.
      repeat (3) begin
         @(negedge clk);
         chk("rst_mem_ce", bus.mem_ce_o, 1'b0);
         chk("rst_gnts", {bus.i_gnt_o, bus.d_gnt_o}, 2'b00);
      end
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("first_d_gnt", bus.d_gnt_o, 1'b1);
      @(posedge clk); #1;
      bus.i_req_i = 1'b0; bus.d_req_i = 1'b0;

      // Single fetch.
      @(posedge clk); #1;
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h100;
      @(negedge clk);
      chk("fetch_gnt", bus.i_gnt_o, 1'b1);
      chk("fetch_addr", bus.mem_addr_o, 32'h100);
      chk("fetch_sel", bus.mem_sel_o, 4'hF);
      @(posedge clk); #1 bus.i_req_i = 1'b0;
      @(negedge clk);
      chk("fetch_rvalid", bus.i_rvalid_o, 1'b1);
      chk("fetch_rdata", bus.i_rdata_o, 32'h0000_0013);
      chk("fetch_no_d", bus.d_rvalid_o, 1'b0);

      // Continuous contention: D,D,D,D,I repeating.
      @(posedge clk); #1;
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h104;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h10; bus.d_lock_i = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("starve_i", bus.i_gnt_o, (k % 5) == 4);
         chk("starve_d", bus.d_gnt_o, (k % 5) != 4);
         @(posedge clk); #1;
      end
      bus.i_req_i = 1'b0; bus.d_req_i = 1'b0;
      @(posedge clk); #1;

      // Back-to-back partial write then read of the same word.
      d_issue(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 1'b0);
      d_issue(1'b0, 32'h200, 32'h0, 4'hF, 1'b0);
      bus.d_req_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Locked read-modify-write keeps I out until the unlocking write.
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h108;
      d_issue(1'b0, 32'h300, 32'h0, 4'hF, 1'b1);
      bus.d_req_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("lock_hold_i", bus.i_gnt_o, 1'b0);
         @(posedge clk); #1;
      end
      d_issue(1'b1, 32'h300, 32'h1234_5678, 4'hF, 1'b0);
      bus.d_req_i = 1'b0;
      @(negedge clk);
      chk("unlock_i_gnt", bus.i_gnt_o, 1'b1);
      @(posedge clk); #1 bus.i_req_i = 1'b0;
      @(posedge clk); #1;

      // Reset right after a D grant drops the response.
      d_issue(1'b0, 32'h200, 32'h0, 4'hF, 1'b0);
      rst = 1'b0; bus.d_req_i = 1'b0;
      @(negedge clk);
      chk("midrst_rvalid", bus.d_rvalid_o, 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("postrst_rvalid", bus.d_rvalid_o, 1'b0);
      @(posedge clk); #1;

      // Random traffic with handshake-respecting masters.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         ig = bus.i_gnt_o;
         dg = bus.d_gnt_o;
         @(posedge clk); #1;
         if (!bus.i_req_i || ig) begin
            bus.i_req_i  = ($urandom_range(0, 3) != 0);
            bus.i_addr_i = rnd_addr();
         end
         if (!bus.d_req_i || dg) begin
            bus.d_req_i   = ($urandom_range(0, 2) != 0);
            bus.d_we_i    = $urandom_range(0, 1);
            bus.d_addr_i  = rnd_addr();
            bus.d_wdata_i = $urandom;
            bus.d_sel_i   = 4'($urandom_range(0, 15));
            bus.d_lock_i  = ($urandom_range(0, 4) == 0);
         end
      end
      bus.i_req_i = 1'b0; bus.d_req_i = 1'b0; bus.d_lock_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Two-master arbiter sharing one single-port synchronous memory between the core's instruction-fetch port (I) and load/store/AMO port (D).
- Sits between the core and the unified program/data memory, which replaces the fetch-only ROM path.
- D has fixed priority over I; an anti-starvation counter guarantees I forward progress.
- A bus lock keeps AMO read-modify-write sequences atomic.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte-select width = DATA_W/8)
STARVE_MAX, 4, consecutive contested cycles I may lose before it is forced to win (1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-low reset
i_req_i  in  1  fetch request (read only)
i_addr_i  in  ADDR_W  fetch address
i_gnt_o  out  1  fetch request accepted this cycle
i_rvalid_o  out  1  fetch data valid
i_rdata_o  out  DATA_W  fetch data
d_req_i  in  1  data request
d_we_i  in  1  1 = write
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  write data
d_sel_i  in  DATA_W/8  byte enables
d_lock_i  in  1  hold bus after this access (AMO read phase)
d_gnt_o  out  1  data request accepted this cycle
d_rvalid_o  out  1  data response (read data or write ack)
d_rdata_o  out  DATA_W  data read value
mem_ce_o  out  1  memory access strobe
mem_we_o  out  1  memory write
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_sel_o  out  DATA_W/8  memory byte enables
mem_rdata_i  in  DATA_W  memory read data, valid exactly 1 cycle after mem_ce_o

Behaviour:
- Reset (rst_i==0 at posedge): state UNLOCKED, starve_cnt=0, resp_owner=NONE. All outputs 0.
- Reset mid-operation: a pending response is dropped, and no rvalid is issued after reset.
- Handshake: a master holds req and its address/data fields stable until gnt. gnt is a combinational single-cycle pulse in the cycle the access is driven onto mem_*.
- Response: rvalid pulses exactly 1 cycle after gnt. rdata = mem_rdata_i in that cycle.
- Back-to-back grants are allowed every cycle (throughput 1 access/cycle).
- mem_ce_o = i_gnt_o | d_gnt_o. mem_* fields are muxed from the granted master. When I is granted: mem_we_o=0, mem_sel_o=all ones. When idle: mem_we_o=0 and other fields 0.
- rdata outputs are driven with mem_rdata_i only when the matching rvalid=1; otherwise 0.
- resp_owner register is updated each cycle to the granted master (or NONE) and steers rvalid/rdata next cycle.
- Decision in UNLOCKED state:
  - Only I requests: grant I.
  - Only D requests: grant D.
  - Both request and starve_cnt==STARVE_MAX: grant I.
  - Both request otherwise: grant D.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when i_req_i=1 and I is not granted.
  - Clears when I is granted, or when i_req_i=0.
- Lock:
  - A D grant with d_lock_i=1 moves the state to LOCKED.
  - In LOCKED, only D may be granted and I waits; starve_cnt still increments but is not honoured.
  - A D grant with d_lock_i=0 in LOCKED returns the state to UNLOCKED from the next cycle.
  - LOCKED with no D request: stay LOCKED and grant nothing.
- Never both gnt in the same cycle; never more than one rvalid per cycle.

Test Plan:
- Reset: hold rst_i=0 3 cycles with both reqs high -> all gnt/rvalid/mem_ce_o=0. After release, first cycle -> d_gnt_o=1.
- Single fetch: i_req_i=1, i_addr_i=0x100, memory returns 0x00000013 -> i_gnt_o in cycle N, mem_addr_o=0x100, mem_sel_o=4'hF; i_rvalid_o=1 with i_rdata_o=0x00000013 at N+1; d_rvalid_o stays 0.
- Contention/starvation (STARVE_MAX=4): both reqs held continuously -> D granted 4 cycles, I granted in 5th, then D again; grant pattern repeats D,D,D,D,I.
- Back-to-back: D write 0x200 data 0xDEADBEEF sel 4'b0011, then D read 0x200 next cycle -> gnt both consecutive cycles, mem_we_o 1 then 0, d_rvalid_o pulses 2 consecutive cycles.
- AMO lock: D read 0x300 with d_lock_i=1 while I requests, D idle 2 cycles, then D write 0x300 with lock=0 -> I not granted until the cycle after the write grant, then i_gnt_o=1.
- Reset mid-access: assert rst_i=0 in the cycle after a D grant -> d_rvalid_o=0 that cycle and stays 0 after release.
